vnu_param: RTL and testbench

Parametrised, pipelined Variable Node Unit for the LDPC decoder datapath. Accepts DV sign-magnitude check-to-variable messages plus one intrinsic LLR per sample. Produces DV saturated sign-magnitude extrinsic variable-to-check messages and a hard decision. Sits between the intrinsic RAM / CNU message network and the CNU input, replacing the fixed degree-3 VNU. Adds valid tracking, a first-iteration mode, saturation reporting and reset.

---
 rtl/vnu_param.sv | 112 +++++++++++
 tb/tb_vnu_param.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vnu_param.sv
// Pipelined LDPC variable node unit: sign-magnitude edge messages plus intrinsic LLR in,
// saturated sign-magnitude extrinsic messages, hard decision and saturation flag out.
module vnu_param #(
    parameter int DV    = 3,
    parameter int MSG_W = 5,
    parameter int OUT_W = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  in_valid,
    input  logic                  first_iter,
    input  logic [DV*MSG_W-1:0]   X,
    input  logic [MSG_W-1:0]      Z,
    output logic                  out_valid,
    output logic [DV*OUT_W-1:0]   Y,
    output logic                  hard_decision,
    output logic                  sat_any
);

    localparam int SUM_W = MSG_W + $clog2(DV + 1) + 1;
    // One bit wider than both the sum and the output so |e| and MAXMAG compare without overflow.
    localparam int AW    = ((SUM_W > OUT_W) ? SUM_W : OUT_W) + 1;
    localparam logic [AW-1:0] MAXMAG = {{(AW - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};

    function automatic logic signed [SUM_W-1:0] sm_to_tc(input logic [MSG_W-1:0] v);
        logic signed [SUM_W-1:0] mag;
        mag = {{(SUM_W - MSG_W + 1){1'b0}}, v[MSG_W-2:0]};
        return v[MSG_W-1] ? -mag : mag;
    endfunction

    function automatic logic [AW-1:0] abs_w(input logic signed [SUM_W-1:0] e);
        logic signed [AW-1:0] ew;
        ew = {{(AW - SUM_W){e[SUM_W-1]}}, e};
        return ew[AW-1] ? -ew : ew;
    endfunction

    function automatic logic is_sat(input logic signed [SUM_W-1:0] e);
        return abs_w(e) > MAXMAG;
    endfunction

    function automatic logic [OUT_W-1:0] sat_sm(input logic signed [SUM_W-1:0] e);
        logic [AW-1:0] mag;
        mag = abs_w(e);
        if (mag > MAXMAG) begin
            mag = MAXMAG;
        end
        return {e[SUM_W-1] && (mag != '0), mag[OUT_W-2:0]};
    endfunction

    logic signed [SUM_W-1:0] x_p1_d [DV];
    logic signed [SUM_W-1:0] x_p1_q [DV];
    logic signed [SUM_W-1:0] total_p1_d, total_p1_q;
    logic                    vld_p1_q;

    logic [DV*OUT_W-1:0]     y_p2_d, y_p2_q;
    logic                    hd_p2_d, hd_p2_q;
    logic                    sat_p2_d, sat_p2_q;
    logic                    vld_p2_q;

    // Stage 1: sign-magnitude to two's complement, total LLR
    always_comb begin
        total_p1_d = sm_to_tc(Z);
        for (int i = 0; i < DV; i++) begin
            x_p1_d[i]  = first_iter ? '0 : sm_to_tc(X[i*MSG_W +: MSG_W]);
            total_p1_d = total_p1_d + x_p1_d[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_p1_q     <= '{default: '0};
            total_p1_q <= '0;
            vld_p1_q   <= 1'b0;
        end else if (en) begin
            x_p1_q     <= x_p1_d;
            total_p1_q <= total_p1_d;
            vld_p1_q   <= in_valid;
        end
    end

    // Stage 2: extrinsic subtraction, saturation, hard decision
    always_comb begin
        y_p2_d   = '0;
        sat_p2_d = 1'b0;
        for (int i = 0; i < DV; i++) begin
            y_p2_d[i*OUT_W +: OUT_W] = sat_sm(total_p1_q - x_p1_q[i]);
            sat_p2_d                 = sat_p2_d | is_sat(total_p1_q - x_p1_q[i]);
        end
        hd_p2_d = !total_p1_q[SUM_W-1] && (total_p1_q != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_p2_q   <= '0;
            hd_p2_q  <= 1'b0;
            sat_p2_q <= 1'b0;
            vld_p2_q <= 1'b0;
        end else if (en) begin
            y_p2_q   <= y_p2_d;
            hd_p2_q  <= hd_p2_d;
            sat_p2_q <= sat_p2_d;
            vld_p2_q <= vld_p1_q;
        end
    end

    assign Y             = y_p2_q;
    assign hard_decision = hd_p2_q;
    assign sat_any       = sat_p2_q;
    assign out_valid     = vld_p2_q;

endmodule

// File: tb/tb_vnu_param.sv
// Bench for vnu_param: integer reference model with per-cycle compare, plus directed
// vectors with hand-computed results at DV=3/OUT_W=6 and DV=6/OUT_W=7.
module tb_vnu_param;

    logic        clk = 1'b0;
    logic        rst_n, en;
    logic        iv_a, fi_a, ov_a, hd_a, sa_a;
    logic [14:0] x_a;
    logic [4:0]  z_a;
    logic [17:0] y_a;
    logic        iv_b, fi_b, ov_b, hd_b, sa_b;
    logic [29:0] x_b;
    logic [4:0]  z_b;
    logic [41:0] y_b;

    always #5 clk = ~clk;

    vnu_param #(.DV(3), .MSG_W(5), .OUT_W(6)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(iv_a), .first_iter(fi_a),
        .X(x_a), .Z(z_a), .out_valid(ov_a), .Y(y_a), .hard_decision(hd_a), .sat_any(sa_a)
    );

    vnu_param #(.DV(6), .MSG_W(5), .OUT_W(7)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(iv_b), .first_iter(fi_b),
        .X(x_b), .Z(z_b), .out_valid(ov_b), .Y(y_b), .hard_decision(hd_b), .sat_any(sa_b)
    );

    typedef struct {
        int          due;
        logic [41:0] y;
        logic        hd;
        logic        sat;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t mr;
    int   en_edges = 0;
    int   ov_cnt_a = 0;
    int   n_tests  = 0;
    int   n_fail   = 0;
    logic ea, eb;

    localparam logic [14:0] X_BASIC = {5'b10001, 5'b00010, 5'b00011};
    localparam logic [14:0] X_SATP  = {5'b01111, 5'b01111, 5'b01111};
    localparam logic [14:0] X_SATN  = {5'b11111, 5'b11111, 5'b11111};
    localparam logic [14:0] X_ZERO  = {5'b10010, 5'b00010, 5'b10000};
    localparam logic [14:0] X_FIRST = {5'b00001, 5'b11001, 5'b00111};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sm2int(input logic [4:0] v);
        int m;
        m = int'(v[3:0]);
        return v[4] ? -m : m;
    endfunction

    // Reference: integer LLR arithmetic straight from the node equations.
    function automatic exp_t model(input int dv, input int ow, input logic [29:0] x,
                                   input logic [4:0] z, input logic fi);
        int   xi[6];
        int   tot, e, m, maxm;
        exp_t r;
        maxm  = (1 << (ow - 1)) - 1;
        tot   = sm2int(z);
        r.due = 0;
        r.y   = '0;
        r.sat = 1'b0;
        for (int i = 0; i < dv; i++) begin
            xi[i] = fi ? 0 : sm2int(x[i*5 +: 5]);
            tot   = tot + xi[i];
        end
        for (int i = 0; i < dv; i++) begin
            e = tot - xi[i];
            m = (e < 0) ? -e : e;
            if (m > maxm) begin
                m     = maxm;
                r.sat = 1'b1;
            end
            r.y = r.y | ((42'(m) | ((e < 0) ? (42'(1) << (ow - 1)) : 42'(0))) << (i * ow));
        end
        r.hd = (tot > 0);
        return r;
    endfunction

    // Samples accepted on an enabled edge are due one enabled edge later.
    always @(posedge clk) begin
        if (rst_n && en) begin
            en_edges++;
            if (ov_a) ov_cnt_a++;
            if (iv_a) begin
                mr     = model(3, 6, {15'b0, x_a}, z_a, fi_a);
                mr.due = en_edges + 1;
                qa.push_back(mr);
            end
            if (iv_b) begin
                mr     = model(6, 7, x_b, z_b, fi_b);
                mr.due = en_edges + 1;
                qb.push_back(mr);
            end
        end
    end

    always @(negedge rst_n) begin
        qa.delete();
        qb.delete();
    end

    always @(negedge clk) begin
        while (qa.size() > 0 && qa[0].due < en_edges) qa.delete(0);
        while (qb.size() > 0 && qb[0].due < en_edges) qb.delete(0);
        ea = (qa.size() > 0) && (qa[0].due == en_edges);
        eb = (qb.size() > 0) && (qb[0].due == en_edges);
        chk("cmp_a_valid", 64'(ov_a), 64'(ea));
        if (ea) begin
            chk("cmp_a_y", 64'(y_a), 64'(qa[0].y[17:0]));
            chk("cmp_a_hd", 64'(hd_a), 64'(qa[0].hd));
            chk("cmp_a_sat", 64'(sa_a), 64'(qa[0].sat));
        end
        chk("cmp_b_valid", 64'(ov_b), 64'(eb));
        if (eb) begin
            chk("cmp_b_y", 64'(y_b), 64'(qb[0].y));
            chk("cmp_b_hd", 64'(hd_b), 64'(qb[0].hd));
            chk("cmp_b_sat", 64'(sa_b), 64'(qb[0].sat));
        end
    end

    task automatic drive_a(input logic v, input logic [14:0] x, input logic [4:0] z,
                           input logic f, input logic e);
        @(posedge clk);
        #2;
        iv_a = v; x_a = x; z_a = z; fi_a = f; en = e;
        iv_b = 1'b0;
    endtask

    task automatic drive_b(input logic v, input logic [29:0] x, input logic [4:0] z,
                           input logic f);
        @(posedge clk);
        #2;
        iv_b = v; x_b = x; z_b = z; fi_b = f; en = 1'b1;
        iv_a = 1'b0;
    endtask

    task automatic wait_ov(input bit b, input string nm);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (((b ? ov_b : ov_a) !== 1'b1) && k < 8);
        chk({nm, "_valid"}, 64'(b ? ov_b : ov_a), 64'(1));
    endtask

    task automatic run_a(input string nm, input logic [14:0] x, input logic [4:0] z,
                         input logic f, input logic [17:0] ey, input logic ehd, input logic es);
        drive_a(1'b1, x, z, f, 1'b1);
        drive_a(1'b0, '0, '0, 1'b0, 1'b1);
        wait_ov(1'b0, nm);
        chk({nm, "_y"}, 64'(y_a), 64'(ey));
        chk({nm, "_hd"}, 64'(hd_a), 64'(ehd));
        chk({nm, "_sat"}, 64'(sa_a), 64'(es));
    endtask

    task automatic run_b(input string nm, input logic [29:0] x, input logic [4:0] z,
                         input logic [41:0] ey, input logic ehd, input logic es);
        drive_b(1'b1, x, z, 1'b0);
        drive_b(1'b0, '0, '0, 1'b0);
        wait_ov(1'b1, nm);
        chk({nm, "_y"}, 64'(y_b), 64'(ey));
        chk({nm, "_hd"}, 64'(hd_b), 64'(ehd));
        chk({nm, "_sat"}, 64'(sa_b), 64'(es));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [17:0] snap_y;
        logic        snap_v;
        exp_t        pr;

        rst_n = 1'b0; en = 1'b1;
        iv_a = 1'b0; fi_a = 1'b0; x_a = '0; z_a = '0;
        iv_b = 1'b0; fi_b = 1'b0; x_b = '0; z_b = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_valid_a", 64'(ov_a), 64'(0));
        chk("reset_y_a", 64'(y_a), 64'(0));
        chk("reset_hd_a", 64'(hd_a), 64'(0));
        chk("reset_sat_a", 64'(sa_a), 64'(0));
        chk("reset_valid_b", 64'(ov_b), 64'(0));
        rst_n = 1'b1;

        pr = model(3, 6, {15'b0, X_BASIC}, 5'b00100, 1'b0);
        chk("model_basic_y", 64'(pr.y), 64'({6'b001001, 6'b000110, 6'b000101}));
        pr = model(3, 6, {15'b0, X_ZERO}, 5'b10000, 1'b0);
        chk("model_zero_y", 64'(pr.y), 64'({6'b000010, 6'b100010, 6'b000000}));

        run_a("basic", X_BASIC, 5'b00100, 1'b0, {6'b001001, 6'b000110, 6'b000101}, 1'b1, 1'b0);
        run_a("satpos", X_SATP, 5'b01111, 1'b0, {3{6'b011111}}, 1'b1, 1'b1);
        run_a("satneg", X_SATN, 5'b11111, 1'b0, {3{6'b111111}}, 1'b0, 1'b1);
        run_a("zero", X_ZERO, 5'b10000, 1'b0, {6'b000010, 6'b100010, 6'b000000}, 1'b0, 1'b0);
        run_a("first", X_FIRST, 5'b10110, 1'b1, {3{6'b100110}}, 1'b0, 1'b0);

        // Stream of four with a two-cycle stall after the second sample.
        drive_a(1'b0, '0, '0, 1'b0, 1'b1);
        ov_cnt_a = 0;
        drive_a(1'b1, X_BASIC, 5'b00100, 1'b0, 1'b1);
        drive_a(1'b1, X_BASIC, 5'b00100, 1'b1, 1'b1);
        drive_a(1'b1, X_ZERO, 5'b10000, 1'b0, 1'b0);
        snap_y = y_a;
        snap_v = ov_a;
        chk("stall_pre_valid", 64'(snap_v), 64'(1));
        drive_a(1'b1, X_ZERO, 5'b10000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("stall_hold_y", 64'(y_a), 64'(snap_y));
        chk("stall_hold_valid", 64'(ov_a), 64'(snap_v));
        #1;
        en = 1'b1;
        drive_a(1'b1, X_SATP, 5'b01111, 1'b1, 1'b1);
        repeat (4) drive_a(1'b0, '0, '0, 1'b0, 1'b1);
        chk("stream_count", 64'(ov_cnt_a), 64'(4));

        // Asynchronous reset with two samples in flight.
        drive_a(1'b1, X_SATP, 5'b01111, 1'b0, 1'b1);
        drive_a(1'b1, X_BASIC, 5'b00100, 1'b0, 1'b1);
        drive_a(1'b0, '0, '0, 1'b0, 1'b1);
        chk("rst_pre_valid", 64'(ov_a), 64'(1));
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 64'(ov_a), 64'(0));
        chk("rst_y", 64'(y_a), 64'(0));
        chk("rst_hd", 64'(hd_a), 64'(0));
        chk("rst_sat", 64'(sa_a), 64'(0));
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        ov_cnt_a = 0;
        repeat (4) drive_a(1'b0, '0, '0, 1'b0, 1'b1);
        chk("post_rst_count", 64'(ov_cnt_a), 64'(0));
        chk("post_rst_valid", 64'(ov_a), 64'(0));

        run_b("b_basic", {5'd1, 5'd1, 5'd1, 5'b10001, 5'd2, 5'd3}, 5'd4,
              {7'd10, 7'd10, 7'd10, 7'd12, 7'd9, 7'd8}, 1'b1, 1'b0);
        run_b("b_sat", {6{5'b01111}}, 5'b01111, {6{7'b0111111}}, 1'b1, 1'b1);

        repeat (3) drive_b(1'b0, '0, '0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
